// File: rtl/dummy_streamer_pkg.sv
// Shared types and width helpers for the dummy AXIS streamer FIFO.
// Entry layout is {tlast, tkeep, tdata}.
package dummy_streamer_pkg;

  typedef enum logic {
    ST_FWD     = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  function automatic int keep_w(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int entry_w(input int data_width);
    return data_width + keep_w(data_width) + 1;
  endfunction

endpackage

// File: rtl/dummy_streamer_fifo_mem.sv
// FIFO storage for the streamer: register array with one write port and
// an asynchronous read of the head entry.
module streamer_fifo_mem #(
  parameter int WIDTH  = 37,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dummy_streamer_fifo.sv
// AXIS FIFO with cut-through or store-and-forward release and packet-aligned flush.
// Optional beat/packet statistics outputs when DUMMY_STREAMER_STATS_EN is defined.
module dummy_streamer_fifo
  import dummy_streamer_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH_LOG2        = 4,
  parameter int STORE_AND_FORWARD = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     S_AXI_TDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_TKEEP,
  input  logic                      S_AXI_TVALID,
  output logic                      S_AXI_TREADY,
  input  logic                      S_AXI_TLAST,
  output logic [DATA_WIDTH-1:0]     M_AXI_TDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_TKEEP,
  output logic                      M_AXI_TVALID,
  input  logic                      M_AXI_TREADY,
  output logic                      M_AXI_TLAST,
  input  logic                      flush,
  output logic [DEPTH_LOG2:0]       occupancy
`ifdef DUMMY_STREAMER_STATS_EN
  ,
  output logic [31:0]               stat_beats,
  output logic [31:0]               stat_pkts
`endif
);

  localparam int KEEP_W  = keep_w(DATA_WIDTH);
  localparam int ENTRY_W = entry_w(DATA_WIDTH);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]   occ_reg, pkt_cnt_reg;
  state_t                state_reg, state_next;
  logic                  in_pkt_reg, in_pkt_next;
  logic                  alive_reg;
  logic [ENTRY_W-1:0]    head_entry, hold_reg, out_entry;

  logic empty, full, s_ready, m_valid;
  logic push, pop, wr_en, wr_last, pop_last, do_flush;

  assign empty    = (occ_reg == '0);
  assign full     = (occ_reg == FULL_CNT);
  // alive_reg keeps ready low while reset is held and for the first edge after
  assign s_ready  = alive_reg & ((state_reg == ST_DISCARD) | !full);
  assign m_valid  = (STORE_AND_FORWARD != 0) ? (!empty && (pkt_cnt_reg != '0 || full))
                                             : !empty;
  assign push     = S_AXI_TVALID & s_ready;
  assign pop      = m_valid & M_AXI_TREADY;
  assign do_flush = flush & (state_reg == ST_FWD);
  assign wr_en    = push & (state_reg == ST_FWD) & !flush;
  assign wr_last  = wr_en & S_AXI_TLAST;
  assign pop_last = pop & head_entry[ENTRY_W-1];

  streamer_fifo_mem #(
    .WIDTH  (ENTRY_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_reg),
    .wdata ({S_AXI_TLAST, S_AXI_TKEEP, S_AXI_TDATA}),
    .raddr (rd_ptr_reg),
    .rdata (head_entry)
  );

  always_comb begin
    state_next  = state_reg;
    in_pkt_next = in_pkt_reg;
    case (state_reg)
      ST_FWD: begin
        if (flush) begin
          in_pkt_next = 1'b0;
          // A beat with TLAST accepted in the flush cycle closes the packet itself
          if (in_pkt_reg ? !(push & S_AXI_TLAST) : (S_AXI_TVALID & !S_AXI_TLAST))
            state_next = ST_DISCARD;
        end else if (push) begin
          in_pkt_next = !S_AXI_TLAST;
        end
      end
      ST_DISCARD: begin
        if (push & S_AXI_TLAST) state_next = ST_FWD;
      end
      default: state_next = ST_FWD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      occ_reg     <= '0;
      pkt_cnt_reg <= '0;
      state_reg   <= ST_FWD;
      in_pkt_reg  <= 1'b0;
      alive_reg   <= 1'b0;
      hold_reg    <= '0;
    end else begin
      alive_reg  <= 1'b1;
      state_reg  <= state_next;
      in_pkt_reg <= in_pkt_next;
      if (pop) hold_reg <= head_entry;
      if (do_flush) begin
        wr_ptr_reg  <= '0;
        rd_ptr_reg  <= '0;
        occ_reg     <= '0;
        pkt_cnt_reg <= '0;
      end else begin
        if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
        if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        case ({wr_en, pop})
          2'b10:   occ_reg <= occ_reg + CNT_ONE;
          2'b01:   occ_reg <= occ_reg - CNT_ONE;
          default: occ_reg <= occ_reg;
        endcase
        case ({wr_last, pop_last})
          2'b10:   pkt_cnt_reg <= pkt_cnt_reg + CNT_ONE;
          2'b01:   pkt_cnt_reg <= pkt_cnt_reg - CNT_ONE;
          default: pkt_cnt_reg <= pkt_cnt_reg;
        endcase
      end
    end
  end

`ifdef DUMMY_STREAMER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_beats <= '0;
      stat_pkts  <= '0;
    end else begin
      if (pop)      stat_beats <= stat_beats + 32'd1;
      if (pop_last) stat_pkts  <= stat_pkts + 32'd1;
    end
  end
`endif

  // Once drained, the master side keeps showing the last beat that left
  assign out_entry    = empty ? hold_reg : head_entry;
  assign M_AXI_TDATA  = out_entry[DATA_WIDTH-1:0];
  assign M_AXI_TKEEP  = out_entry[DATA_WIDTH +: KEEP_W];
  assign M_AXI_TLAST  = out_entry[ENTRY_W-1];
  assign M_AXI_TVALID = m_valid;
  assign S_AXI_TREADY = s_ready;
  assign occupancy    = occ_reg;

endmodule

// File: tb/tb_dummy_streamer_fifo.sv
// Directed bench for dummy_streamer_fifo: a cut-through and a store-and-forward
// instance share one stimulus; each step checks the instance it targets.
module tb_dummy_streamer_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid, s_last, mr, flush;
  logic [31:0] s_data;
  logic [3:0]  s_keep;

  logic        ct_s_ready, ct_m_valid, ct_m_last;
  logic [31:0] ct_m_data;
  logic [3:0]  ct_m_keep;
  logic [2:0]  ct_occ;
  logic        saf_s_ready, saf_m_valid, saf_m_last;
  logic [31:0] saf_m_data;
  logic [3:0]  saf_m_keep;
  logic [2:0]  saf_occ;
`ifdef DUMMY_STREAMER_STATS_EN
  logic [31:0] ct_beats, ct_pkts, saf_beats, saf_pkts;
`endif

  int tests = 0;
  int fails = 0;

  logic [36:0] q_ct[$];
  logic [36:0] q_saf[$];
  logic        ct_stall = 1'b0, saf_stall = 1'b0;
  logic [36:0] ct_prev, saf_prev;
  int          ct_pops = 0, ct_lasts = 0, saf_pops = 0, saf_lasts = 0;

  always #5 clk = ~clk;

  dummy_streamer_fifo #(.DATA_WIDTH(32), .DEPTH_LOG2(2), .STORE_AND_FORWARD(0)) dut_ct (
    .clk(clk), .reset(reset),
    .S_AXI_TDATA(s_data), .S_AXI_TKEEP(s_keep), .S_AXI_TVALID(s_valid),
    .S_AXI_TREADY(ct_s_ready), .S_AXI_TLAST(s_last),
    .M_AXI_TDATA(ct_m_data), .M_AXI_TKEEP(ct_m_keep), .M_AXI_TVALID(ct_m_valid),
    .M_AXI_TREADY(mr), .M_AXI_TLAST(ct_m_last),
    .flush(flush), .occupancy(ct_occ)
`ifdef DUMMY_STREAMER_STATS_EN
    , .stat_beats(ct_beats), .stat_pkts(ct_pkts)
`endif
  );

  dummy_streamer_fifo #(.DATA_WIDTH(32), .DEPTH_LOG2(2), .STORE_AND_FORWARD(1)) dut_saf (
    .clk(clk), .reset(reset),
    .S_AXI_TDATA(s_data), .S_AXI_TKEEP(s_keep), .S_AXI_TVALID(s_valid),
    .S_AXI_TREADY(saf_s_ready), .S_AXI_TLAST(s_last),
    .M_AXI_TDATA(saf_m_data), .M_AXI_TKEEP(saf_m_keep), .M_AXI_TVALID(saf_m_valid),
    .M_AXI_TREADY(mr), .M_AXI_TLAST(saf_m_last),
    .flush(flush), .occupancy(saf_occ)
`ifdef DUMMY_STREAMER_STATS_EN
    , .stat_beats(saf_beats), .stat_pkts(saf_pkts)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    mr = 1'b0; flush = 1'b0;
    step();
    @(negedge clk);
    chk("rst_s_ready", {ct_s_ready, saf_s_ready}, 2'b00);
    chk("rst_m_valid", {ct_m_valid, saf_m_valid}, 2'b00);
    chk("rst_m_data", {ct_m_last, ct_m_keep, ct_m_data}, 37'h0);
    chk("rst_occ", {ct_occ, saf_occ}, 6'h0);
    step();
    reset = 1'b1;
    step();
  endtask

  // One random or draining cycle with per-instance scoreboards and stall checks
  task automatic rand_cycle(input bit drain);
    if (drain) begin
      s_valid = 1'b0; mr = 1'b1;
    end else begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = $urandom;
      s_keep  = 4'($urandom_range(0, 15));
      s_last  = ($urandom_range(0, 4) == 0);
      mr      = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    if (ct_stall) chk("r_ct_stable", {ct_m_valid, ct_m_last, ct_m_keep, ct_m_data}, {1'b1, ct_prev});
    if (saf_stall) chk("r_saf_stable", {saf_m_valid, saf_m_last, saf_m_keep, saf_m_data}, {1'b1, saf_prev});
    if (ct_m_valid && mr) begin
      if (q_ct.size() == 0) chk("r_ct_spurious", ct_m_valid, 1'b0);
      else chk("r_ct_data", {ct_m_last, ct_m_keep, ct_m_data}, q_ct.pop_front());
      ct_pops++;
      if (ct_m_last) ct_lasts++;
    end
    if (saf_m_valid && mr) begin
      if (q_saf.size() == 0) chk("r_saf_spurious", saf_m_valid, 1'b0);
      else chk("r_saf_data", {saf_m_last, saf_m_keep, saf_m_data}, q_saf.pop_front());
      saf_pops++;
      if (saf_m_last) saf_lasts++;
    end
    if (s_valid && ct_s_ready)  q_ct.push_back({s_last, s_keep, s_data});
    if (s_valid && saf_s_ready) q_saf.push_back({s_last, s_keep, s_data});
    ct_stall  = ct_m_valid && !mr;
    ct_prev   = {ct_m_last, ct_m_keep, ct_m_data};
    saf_stall = saf_m_valid && !mr;
    saf_prev  = {saf_m_last, saf_m_keep, saf_m_data};
    step();
  endtask

  initial begin
    int sent, recv;
    bit saw_release;

    // 1: cut-through, 3-beat packet, sink always ready
    do_reset();
    mr = 1'b1; s_keep = 4'hF;
    s_valid = 1'b1; s_data = 32'hA1; s_last = 1'b0;
    @(negedge clk);
    chk("t1_ready", ct_s_ready, 1'b1);
    chk("t1_empty_valid", ct_m_valid, 1'b0);
    step();
    s_data = 32'hA2;
    @(negedge clk);
    chk("t1_a1", {ct_m_valid, ct_m_last, ct_m_data}, {2'b10, 32'hA1});
    chk("t1_occ", ct_occ, 3'd1);
    step();
    s_data = 32'hA3; s_last = 1'b1;
    @(negedge clk);
    chk("t1_a2", {ct_m_valid, ct_m_last, ct_m_data}, {2'b10, 32'hA2});
    step();
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("t1_a3", {ct_m_valid, ct_m_last, ct_m_data}, {2'b11, 32'hA3});
    step();
    @(negedge clk);
    chk("t1_drained", {ct_m_valid, ct_occ}, 4'h0);
    chk("t1_hold", {ct_m_last, ct_m_data}, {1'b1, 32'hA3});
    step();

    // 2: sink stalled, five beats offered, four fit
    do_reset();
    s_keep = 4'hF;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'hD1 + i; s_last = 1'b0;
      @(negedge clk);
      chk("t2_ready_fill", ct_s_ready, 1'b1);
      step();
    end
    s_data = 32'hD5; s_last = 1'b1;
    @(negedge clk);
    chk("t2_full_ready", ct_s_ready, 1'b0);
    chk("t2_full_occ", ct_occ, 3'd4);
    chk("t2_head", {ct_m_valid, ct_m_data}, {1'b1, 32'hD1});
    mr = 1'b1;
    #1;
    chk("t2_no_comb_ready", ct_s_ready, 1'b0);
    step();
    @(negedge clk);
    chk("t2_d2", {ct_occ, ct_s_ready, ct_m_data}, {3'd3, 1'b1, 32'hD2});
    step();
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("t2_d3", {ct_occ, ct_m_data}, {3'd3, 32'hD3});
    step();
    @(negedge clk);
    chk("t2_d4", {ct_occ, ct_m_data}, {3'd2, 32'hD4});
    step();
    @(negedge clk);
    chk("t2_d5", {ct_occ, ct_m_last, ct_m_data}, {3'd1, 1'b1, 32'hD5});
    step();
    @(negedge clk);
    chk("t2_empty", {ct_m_valid, ct_occ}, 4'h0);
    step();

    // 3: store-and-forward holds output until TLAST is stored
    do_reset();
    mr = 1'b1; s_keep = 4'hF;
    s_valid = 1'b1; s_data = 32'hB1; s_last = 1'b0;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("t3_gap1", {saf_m_valid, saf_occ}, {1'b0, 3'd1});
    step();
    @(negedge clk);
    chk("t3_gap2", saf_m_valid, 1'b0);
    step();
    s_valid = 1'b1; s_data = 32'hB2; s_last = 1'b1;
    @(negedge clk);
    chk("t3_last_cycle", saf_m_valid, 1'b0);
    step();
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("t3_b1", {saf_m_valid, saf_m_last, saf_m_data}, {2'b10, 32'hB1});
    step();
    @(negedge clk);
    chk("t3_b2", {saf_m_valid, saf_m_last, saf_m_data}, {2'b11, 32'hB2});
    step();
    @(negedge clk);
    chk("t3_empty", saf_m_valid, 1'b0);
    step();

    // 4: store-and-forward, packet longer than the FIFO
    do_reset();
    mr = 1'b1; s_keep = 4'hF;
    sent = 0; recv = 0; saw_release = 1'b0;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      s_valid = (sent < 6); s_data = 32'hE1 + sent; s_last = (sent == 5);
      @(negedge clk);
      if (saf_occ == 3'd4 && saf_m_valid && !saf_s_ready && recv == 0) saw_release = 1'b1;
      if (saf_m_valid) begin
        chk("t4_data", {saf_m_last, saf_m_data}, {recv == 5, 32'hE1 + recv});
        recv++;
      end
      if (s_valid && saf_s_ready) sent++;
      step();
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("t4_count", recv, 6);
    chk("t4_full_release", saw_release, 1'b1);

    // 5: flush mid-packet, rest of packet dropped, next packet intact
    do_reset();
    s_keep = 4'hF;
    s_valid = 1'b1; s_data = 32'hF1; s_last = 1'b0;
    step();
    s_data = 32'hF2;
    step();
    s_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("t5_pre_flush_occ", ct_occ, 3'd2);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t5_flushed", {ct_m_valid, ct_occ}, 4'h0);
    step();
    s_valid = 1'b1; s_data = 32'hF3;
    @(negedge clk);
    chk("t5_discard_ready", ct_s_ready, 1'b1);
    step();
    s_data = 32'hF4; s_last = 1'b1;
    @(negedge clk);
    chk("t5_discard_ready_last", {ct_s_ready, ct_occ}, {1'b1, 3'd0});
    step();
    s_data = 32'hC1; mr = 1'b1;
    @(negedge clk);
    chk("t5_dropped", {ct_m_valid, ct_occ}, 4'h0);
    step();
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("t5_c1", {ct_m_valid, ct_m_last, ct_m_data, ct_occ}, {2'b11, 32'hC1, 3'd1});
    step();

    // 6: random traffic on both instances
    do_reset();
    for (int c = 0; c < 3000; c++) rand_cycle(1'b0);
    for (int c = 0; c < 30; c++) rand_cycle(1'b1);
    chk("r_ct_left", ct_occ, q_ct.size());
    chk("r_saf_left", saf_occ, q_saf.size());
`ifdef DUMMY_STREAMER_STATS_EN
    chk("ct_stat_beats", ct_beats, ct_pops);
    chk("ct_stat_pkts", ct_pkts, ct_lasts);
    chk("saf_stat_beats", saf_beats, saf_pops);
    chk("saf_stat_pkts", saf_pkts, saf_lasts);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
